// File: rtl/rf_wb_merge_if.sv
// Write-port merge bundle: pipeline write-back, remote-load return handshake,
// hazard query and the registered register-file write port.
interface rf_wb_merge_if #(
  parameter int width_p      = 32,
  parameter int addr_width_p = 5
);
  logic                    pipe_v_i;
  logic [addr_width_p-1:0] pipe_addr_i;
  logic [width_p-1:0]      pipe_data_i;
  logic                    ret_v_i;
  logic [addr_width_p-1:0] ret_addr_i;
  logic [width_p-1:0]      ret_data_i;
  logic                    ret_ready_o;
  logic                    stall_o;
  logic [addr_width_p-1:0] chk_addr_i;
  logic                    chk_hit_o;
  logic                    w_v_o;
  logic [addr_width_p-1:0] w_addr_o;
  logic [width_p-1:0]      w_data_o;

  modport master (
    output pipe_v_i, pipe_addr_i, pipe_data_i,
    output ret_v_i, ret_addr_i, ret_data_i, chk_addr_i,
    input  ret_ready_o, stall_o, chk_hit_o,
    input  w_v_o, w_addr_o, w_data_o
  );

  modport slave (
    input  pipe_v_i, pipe_addr_i, pipe_data_i,
    input  ret_v_i, ret_addr_i, ret_data_i, chk_addr_i,
    output ret_ready_o, stall_o, chk_hit_o,
    output w_v_o, w_addr_o, w_data_o
  );
endinterface

// File: rtl/rf_wb_merge.sv
// rf_wb_merge: drives the register-file write port from the pipeline write-back
// stream and a buffered remote-load return stream. Option macro: RF_WB_MERGE_X0_DROP_EN.

module rf_wb_merge_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic pipe_v_i,
  input logic stall_o
);
  a_no_pipe_on_stall: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       !(pipe_v_i && stall_o))
    else $error("rf_wb_merge: pipe_v_i asserted while stall_o is high");
endmodule

module rf_wb_merge #(
  parameter int width_p    = 32,
  parameter int els_p      = 32,
  parameter int fifo_els_p = 2,
  parameter int max_wait_p = 4
) (
  input logic          clk_i,
  input logic          reset_n_i,
  rf_wb_merge_if.slave bus
);
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int ptr_width_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_width_lp  = ptr_width_lp + 1;
  localparam int wait_width_lp = (max_wait_p > 0) ? $clog2(max_wait_p + 1) : 1;

  localparam logic [cnt_width_lp-1:0]  full_cnt_lp  = cnt_width_lp'(fifo_els_p);
  localparam logic [wait_width_lp-1:0] max_wait_lp  = wait_width_lp'(max_wait_p);
  localparam logic [wait_width_lp-1:0] pre_stall_lp = wait_width_lp'(max_wait_p - 2);

  logic [addr_width_lp-1:0] addr_mem_r [fifo_els_p];
  logic [width_p-1:0]       data_mem_r [fifo_els_p];
  logic [ptr_width_lp-1:0]  rd_ptr_r;
  logic [ptr_width_lp-1:0]  wr_ptr_r;
  logic [cnt_width_lp-1:0]  count_r;
  logic [wait_width_lp-1:0] wait_r;
  logic                     stall_r;
  logic                     w_v_r;
  logic [addr_width_lp-1:0] w_addr_r;
  logic [width_p-1:0]       w_data_r;

  logic empty_s;
  logic full_s;
  logic ready_s;
  logic pipe_take_s;
  logic ret_keep_s;
  logic push_s;
  logic pop_s;
  logic hit_s;

  // Distance of a storage slot from the head; slots closer than count_r are live.
  function automatic logic [cnt_width_lp-1:0] slot_offset(
    input logic [ptr_width_lp-1:0] slot,
    input logic [ptr_width_lp-1:0] head
  );
    logic [ptr_width_lp-1:0] off;
    off = slot - head;
    return {1'b0, off};
  endfunction

`ifdef RF_WB_MERGE_X0_DROP_EN
  assign pipe_take_s = bus.pipe_v_i & (bus.pipe_addr_i != {addr_width_lp{1'b0}});
  assign ret_keep_s  = (bus.ret_addr_i != {addr_width_lp{1'b0}});
`else
  assign pipe_take_s = bus.pipe_v_i;
  assign ret_keep_s  = 1'b1;
`endif

  assign empty_s = (count_r == {cnt_width_lp{1'b0}});
  assign full_s  = (count_r == full_cnt_lp);
  // Ready ignores a same-cycle pop so it never depends on the pipeline valid.
  assign ready_s = reset_n_i & ~full_s;
  assign push_s  = bus.ret_v_i & ready_s & ret_keep_s;
  assign pop_s   = ~pipe_take_s & ~empty_s;

  // Hazard query across live buffer entries and a return accepted this cycle
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < fifo_els_p; i++) begin
      if ((slot_offset(ptr_width_lp'(i), rd_ptr_r) < count_r) &&
          (addr_mem_r[i] == bus.chk_addr_i)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
    if (push_s && (bus.ret_addr_i == bus.chk_addr_i)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = hit_s;
    end
  end

  // Return buffer storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= {ptr_width_lp{1'b0}};
      wr_ptr_r <= {ptr_width_lp{1'b0}};
      count_r  <= {cnt_width_lp{1'b0}};
      for (int i = 0; i < fifo_els_p; i++) begin
        addr_mem_r[i] <= {addr_width_lp{1'b0}};
        data_mem_r[i] <= {width_p{1'b0}};
      end
    end else begin
      if (push_s) begin
        addr_mem_r[wr_ptr_r] <= bus.ret_addr_i;
        data_mem_r[wr_ptr_r] <= bus.ret_data_i;
        wr_ptr_r             <= wr_ptr_r + ptr_width_lp'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_width_lp'(1'b1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter; the bubble request fires as the count reaches max_wait_p-1
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_r  <= {wait_width_lp{1'b0}};
      stall_r <= 1'b0;
    end else begin
      if (pop_s || empty_s) begin
        wait_r <= {wait_width_lp{1'b0}};
      end else if (wait_r == max_wait_lp) begin
        wait_r <= wait_r;
      end else begin
        wait_r <= wait_r + wait_width_lp'(1'b1);
      end
      stall_r <= ~pop_s & ~empty_s & (wait_r == pre_stall_lp);
    end
  end

  // Registered write port; address and data hold while idle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_r    <= 1'b0;
      w_addr_r <= {addr_width_lp{1'b0}};
      w_data_r <= {width_p{1'b0}};
    end else if (pipe_take_s) begin
      w_v_r    <= 1'b1;
      w_addr_r <= bus.pipe_addr_i;
      w_data_r <= bus.pipe_data_i;
    end else if (pop_s) begin
      w_v_r    <= 1'b1;
      w_addr_r <= addr_mem_r[rd_ptr_r];
      w_data_r <= data_mem_r[rd_ptr_r];
    end else begin
      w_v_r    <= 1'b0;
      w_addr_r <= w_addr_r;
      w_data_r <= w_data_r;
    end
  end

  assign bus.ret_ready_o = ready_s;
  assign bus.stall_o     = stall_r;
  assign bus.chk_hit_o   = hit_s;
  assign bus.w_v_o       = w_v_r;
  assign bus.w_addr_o    = w_addr_r;
  assign bus.w_data_o    = w_data_r;

  rf_wb_merge_chk u_chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .pipe_v_i  (bus.pipe_v_i),
    .stall_o   (stall_r)
  );
endmodule

// File: tb/tb_rf_wb_merge.sv
// Bench for rf_wb_merge: directed scenarios then random traffic, each cycle
// compared with a queue-based model of the merge rules.
module tb_rf_wb_merge;
  localparam int W   = 16;
  localparam int ELS = 32;
  localparam int AW  = 5;
  localparam int FE  = 2;
  localparam int MW  = 4;
`ifdef RF_WB_MERGE_X0_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_merge_if #(.width_p(W), .addr_width_p(AW)) bus ();

  rf_wb_merge #(.width_p(W), .els_p(ELS), .fifo_els_p(FE), .max_wait_p(MW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int checks;
  int errors;

  // reference model state
  ent_t          q[$];
  int            m_wait;
  bit            m_stall;
  bit            m_wv;
  logic [AW-1:0] m_wa;
  logic [W-1:0]  m_wd;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_wait  = 0;
    m_stall = 1'b0;
    m_wv    = 1'b0;
    m_wa    = '0;
    m_wd    = '0;
  endtask

  task automatic drive_idle();
    bus.pipe_v_i    = 1'b0;
    bus.pipe_addr_i = '0;
    bus.pipe_data_i = '0;
    bus.ret_v_i     = 1'b0;
    bus.ret_addr_i  = '0;
    bus.ret_data_i  = '0;
    bus.chk_addr_i  = '0;
  endtask

  // Entered at posedge+1; checks registered outputs, drives, checks
  // combinational outputs, advances the model, ends at next posedge+1.
  task automatic cycle(input logic pv, input logic [AW-1:0] pa, input logic [W-1:0] pd,
                       input logic rv, input logic [AW-1:0] ra, input logic [W-1:0] rd,
                       input logic [AW-1:0] ca);
    bit   take, keep, acc, exp_ready, exp_hit, was_empty, popped;
    ent_t e;
    check_eq("w_v", bus.w_v_o, m_wv);
    check_eq("w_addr", bus.w_addr_o, m_wa);
    check_eq("w_data", bus.w_data_o, m_wd);
    check_eq("stall", bus.stall_o, m_stall);
    if (m_stall) pv = 1'b0;
    bus.pipe_v_i    = pv;
    bus.pipe_addr_i = pa;
    bus.pipe_data_i = pd;
    bus.ret_v_i     = rv;
    bus.ret_addr_i  = ra;
    bus.ret_data_i  = rd;
    bus.chk_addr_i  = ca;
    #1;
    exp_ready = (q.size() < FE);
    acc       = rv && exp_ready;
    keep      = !(DROP && (ra == '0));
    exp_hit   = acc && keep && (ra == ca);
    foreach (q[i]) if (q[i].a == ca) exp_hit = 1'b1;
    check_eq("ret_ready", bus.ret_ready_o, exp_ready);
    check_eq("chk_hit", bus.chk_hit_o, exp_hit);

    take      = pv && !(DROP && (pa == '0));
    was_empty = (q.size() == 0);
    popped    = 1'b0;
    if (take) begin
      m_wv = 1'b1; m_wa = pa; m_wd = pd;
    end else if (!was_empty) begin
      e = q.pop_front();
      m_wv = 1'b1; m_wa = e.a; m_wd = e.d;
      popped = 1'b1;
    end else begin
      m_wv = 1'b0;
    end
    if (popped || was_empty) m_wait = 0;
    else if (m_wait < MW) m_wait++;
    m_stall = !popped && !was_empty && (m_wait == MW - 1);
    if (acc && keep) q.push_back('{a: ra, d: rd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rand_cycle(input int pv_pct, input int rv_pct);
    logic          pv, rv;
    logic [AW-1:0] pa, ra, ca;
    pv = ($urandom_range(99) < pv_pct);
    rv = ($urandom_range(99) < rv_pct);
    pa = AW'($urandom_range(7));
    ra = AW'($urandom_range(7));
    ca = AW'($urandom_range(7));
    cycle(pv, pa, W'($urandom), rv, ra, W'($urandom), ca);
  endtask

  // Asynchronous reset in mid-cycle with a return being offered.
  task automatic reset_pulse();
    bus.pipe_v_i   = 1'b0;
    bus.ret_v_i    = 1'b1;
    bus.ret_addr_i = 5'd9;
    bus.chk_addr_i = 5'd9;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_w_v", bus.w_v_o, 1'b0);
    check_eq("rst_w_addr", bus.w_addr_o, 32'd0);
    check_eq("rst_w_data", bus.w_data_o, 32'd0);
    check_eq("rst_stall", bus.stall_o, 1'b0);
    check_eq("rst_ready", bus.ret_ready_o, 1'b0);
    check_eq("rst_hit", bus.chk_hit_o, 1'b0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    drive_idle();
    #1;
    check_eq("init_ready", bus.ret_ready_o, 1'b0);
    check_eq("init_w_v", bus.w_v_o, 1'b0);
    check_eq("init_stall", bus.stall_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // pipe-only write
    cycle(1'b1, 5'd5, 16'h00A5, 1'b0, '0, '0, '0);
    idle(2);
    // idle drain with hazard query on the returned register
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 16'h0077, 5'd7);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd7);
    idle(2);
    // starvation: pipe kept busy, stall bubble forced by the model's stall
    cycle(1'b1, 5'd1, 16'h0011, 1'b1, 5'd3, 16'h0033, 5'd3);
    repeat (8) cycle(1'b1, 5'd2, W'($urandom), 1'b0, '0, '0, 5'd3);
    idle(2);
    // full buffer with a held third return
    cycle(1'b1, 5'd1, 16'h0101, 1'b1, 5'd4, 16'h0044, 5'd6);
    cycle(1'b1, 5'd1, 16'h0102, 1'b1, 5'd5, 16'h0055, 5'd6);
    cycle(1'b1, 5'd1, 16'h0103, 1'b1, 5'd6, 16'h0066, 5'd6);
    cycle(1'b0, '0, '0, 1'b1, 5'd6, 16'h0066, 5'd6);
    cycle(1'b0, '0, '0, 1'b1, 5'd6, 16'h0066, 5'd6);
    idle(5);
    // x0 traffic on both sources
    cycle(1'b1, 5'd1, 16'h0201, 1'b1, 5'd0, 16'h0BAD, 5'd0);
    cycle(1'b1, 5'd0, 16'h0202, 1'b0, '0, '0, 5'd0);
    idle(4);
    // reset with two returns buffered
    cycle(1'b1, 5'd1, 16'h0301, 1'b1, 5'd8, 16'h0088, 5'd8);
    cycle(1'b1, 5'd1, 16'h0302, 1'b1, 5'd9, 16'h0099, 5'd9);
    reset_pulse();
    idle(4);

    // random traffic in phases of differing pipeline load
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(249) == 0) reset_pulse();
        case (ph)
          0:       rand_cycle(90, 60);
          1:       rand_cycle(50, 80);
          2:       rand_cycle(10, 30);
          default: rand_cycle(70, 50);
        endcase
      end
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
